// File: rtl/shift_add_mult.sv
// Sequential unsigned N x N shift-add multiplier built on a ripple-carry adder.
// One partial product is accumulated per cycle; product is held until the next completion.

module rca_add #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);
   logic [N:0] carry;

   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_fa
         assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = carry[N];
endmodule

module shift_add_mult #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_reg, state_next;
   logic [N-1:0]    mcand_reg, mcand_next;
   logic [N-1:0]    hi_reg, hi_next;
   logic [N-1:0]    lo_reg, lo_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2*N-1:0]  product_reg, product_next;
   logic            busy_reg, busy_next;
   logic            done_reg, done_next;

   logic [N-1:0]    sum;
   logic            cout;

   rca_add #(.N(N)) u_add (
      .a    (hi_reg),
      .b    (mcand_reg),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   always_comb begin
      state_next   = state_reg;
      mcand_next   = mcand_reg;
      hi_next      = hi_reg;
      lo_next      = lo_reg;
      cnt_next     = cnt_reg;
      product_next = product_reg;

      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               mcand_next = a;
               lo_next    = b;
               hi_next    = '0;
               cnt_next   = '0;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         RUN: begin
            // cout becomes the top bit of the shifted accumulator
            if (lo_reg[0])
               {hi_next, lo_next} = {cout, sum, lo_reg[N-1:1]};
            else
               {hi_next, lo_next} = {1'b0, hi_reg, lo_reg[N-1:1]};
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(N - 1)) begin
               product_next = {hi_next, lo_next};
               state_next   = DONE;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next == RUN);
      done_next = (state_next == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         mcand_reg   <= '0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         mcand_reg   <= mcand_next;
         hi_reg      <= hi_next;
         lo_reg      <= lo_next;
         cnt_reg     <= cnt_next;
         product_reg <= product_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign product = product_reg;
endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (N = 4): spec vector table, corner sequences,
// and random operands checked against plain a*b arithmetic.

module tb_shift_add_mult;
   localparam int N = 4;

   logic           clk;
   logic           rst;
   logic           start;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int n_cmp;
   int n_bad;
   logic [2*N-1:0] prod_model;

   shift_add_mult #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [N-1:0]   va;
      logic [N-1:0]   vb;
      logic [2*N-1:0] vp;
      int             pulse_at;
      int             gap;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_check(input string name);
      @(posedge clk); #1;
      check({name, "_busy"}, 16'(busy), 16'd0);
      check({name, "_done"}, 16'(done), 16'd0);
      check({name, "_prod"}, 16'(product), 16'(prod_model));
   endtask

   // Caller is 1ns past an edge; leaves the bench 1ns past the done edge.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                         input logic [2*N-1:0] exp, input int pulse_at);
      a = ta; b = tb_; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = N'($urandom); b = N'($urandom);
      check("start_busy", 16'(busy), 16'd1);
      check("start_done", 16'(done), 16'd0);
      check("start_hold", 16'(product), 16'(prod_model));
      for (int i = 1; i < N; i++) begin
         if (i == pulse_at) begin
            start = 1'b1; a = 4'b0001;
         end
         @(posedge clk); #1;
         start = 1'b0;
         check("run_busy", 16'(busy), 16'd1);
         check("run_done", 16'(done), 16'd0);
         check("run_hold", 16'(product), 16'(prod_model));
      end
      @(posedge clk); #1;
      prod_model = exp;
      $display("op a=%0d b=%0d -> product=%0d (expect %0d) done=%0b", ta, tb_, product, exp, done);
      check("fin_done", 16'(done), 16'd1);
      check("fin_busy", 16'(busy), 16'd0);
      check("fin_prod", 16'(product), 16'(exp));
   endtask

   initial begin
      logic [N-1:0]   ra;
      logic [N-1:0]   rb;
      logic [2*N-1:0] rexp;

      n_cmp = 0; n_bad = 0; prod_model = '0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;

      // reset then idle
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) idle_check("reset_idle");

      // spec vectors; gap 0 means the next start lands in the DONE cycle
      vecs[0] = '{4'b0110, 4'b1101, 8'd78,  -1, 1};
      vecs[1] = '{4'b1111, 4'b1111, 8'd225, -1, 1};
      vecs[2] = '{4'b0000, 4'b1011, 8'h00,  -1, 0};
      vecs[3] = '{4'b1001, 4'b0001, 8'h09,  -1, 1};
      vecs[4] = '{4'b0111, 4'b1110, 8'h62,   2, 0};
      vecs[5] = '{4'b0010, 4'b1001, 8'h12,  -1, 1};
      vecs[6] = '{4'b1111, 4'b0001, 8'h0f,  -1, 1};
      for (int v = 0; v < 7; v++) begin
         run_op(vecs[v].va, vecs[v].vb, vecs[v].vp, vecs[v].pulse_at);
         for (int g = 0; g < vecs[v].gap; g++) idle_check("vec_gap");
      end

      // reset on the 2nd RUN edge abandons the operation
      a = 4'b1110; b = 4'b1000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      prod_model = '0;
      check("midrst_busy", 16'(busy), 16'd0);
      check("midrst_done", 16'(done), 16'd0);
      check("midrst_prod", 16'(product), 16'd0);
      for (int i = 0; i < 6; i++) idle_check("midrst_idle");
      run_op(4'b0011, 4'b0011, 8'h09, -1);
      idle_check("post_midrst");

      // reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; a = 4'b0101; b = 4'b0101;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      prod_model = '0;
      check("rststart_busy", 16'(busy), 16'd0);
      check("rststart_prod", 16'(product), 16'd0);
      for (int i = 0; i < 6; i++) idle_check("rststart_idle");

      // random operands against plain multiplication
      for (int r = 0; r < 25; r++) begin
         ra = N'($urandom_range(0, 15));
         rb = N'($urandom_range(0, 15));
         rexp = (2*N)'(ra) * (2*N)'(rb);
         run_op(ra, rb, rexp, ($urandom_range(0, 3) == 0) ? 1 : -1);
         if ($urandom_range(0, 1) == 1) idle_check("rand_gap");
      end
      idle_check("final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential unsigned N×N multiplier that consumes the ripple-carry adder: one `rca_add #(.N(N))` instance accumulates one partial product per cycle, and the result is shifted right each step. Operands are loaded on a start pulse. The 2N-bit product is ready after N iterations and is held until the next completion. The block is the first multi-cycle arithmetic stage built on the adder.

## Interface
- `N`, default 4: operand width in bits; N ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a multiply; sampled only when `busy` = 0.
- `a`  in  N: multiplicand, unsigned; captured on the accepted start.
- `b`  in  N: multiplier, unsigned; captured on the accepted start.
- `busy`  out  1: high while iterations are in progress.
- `done`  out  1: one-cycle pulse when `product` updates.
- `product`  out  2N: result register, unsigned.

## Operation
- One clock. Reset is synchronous and active-high.
- States:
  - IDLE: waiting for a start.
  - RUN: iterating.
  - DONE: one-cycle completion state.
- Internal registers:
  - `mcand[N-1:0]`
  - `hi[N-1:0]`, the accumulator upper half
  - `lo[N-1:0]`, the multiplier being shifted out
  - `cnt`, ceil(log2(N+1)) bits
- Start acceptance:
  - A start is accepted when `start` = 1 in IDLE or DONE.
  - On acceptance: mcand←a, lo←b, hi←0, cnt←0, go to RUN.
- Each RUN edge:
  - The adder computes `{cout, sum} = hi + mcand` with `cin` = 0.
  - If lo[0] = 1: `{hi, lo} ← {cout, sum, lo} >> 1`.
  - Else: `{hi, lo} ← {1'b0, hi, lo} >> 1`.
  - cnt←cnt+1.
- On the RUN edge where cnt = N-1:
  - Perform the final iteration.
  - Load `product` with the post-shift `{hi, lo}`.
  - Go to DONE.
- DONE lasts exactly one cycle. Next state is RUN if `start` is accepted, else IDLE.
- `start` while in RUN is ignored. The operation in flight is unaffected.
- Arithmetic is unsigned only. The product never overflows 2N bits. The adder's `cout` is the (N+1)th bit shifted into `hi`.
- `product` changes only at completion or reset. It holds its value through IDLE and through the whole of a following RUN.
- Reset during any state:
  - State goes to IDLE on that edge.
  - The operation in flight is abandoned.
  - `product` goes to 0.
- Simultaneous `rst` and `start`: reset wins and the start is dropped.

## Timing
- Reset values:
  - `busy` = 0, `done` = 0, `product` = 0.
  - State = IDLE.
  - Internal registers = 0.
- `busy` = (state == RUN), registered. `done` = (state == DONE), registered.
- Start sampled at edge k:
  - `busy` = 1 after edges k through k+N-1.
  - Iterations occur at edges k+1 … k+N.
  - After edge k+N: `done` = 1, `busy` = 0, `product` valid.
- Latency is N+1 edges from the start edge to the `done` edge, which is 5 for N = 4.
- Back-to-back operation: a start accepted in the DONE cycle gives `busy` = 1 on the very next cycle. Throughput is one result every N+1 cycles.
- There is no combinational path from any input to any output.
- The adder path hi→rca_add→hi is the critical path. It is one N-bit ripple per cycle.

## Test plan
- Reset then idle: hold `rst` 2 cycles, then 10 idle cycles → `busy` = 0, `done` = 0, `product` = 8'h00 throughout.
- Basic (N = 4): a = 4'b0110, b = 4'b1101, start 1 cycle → `busy` high 4 cycles, `done` pulses on the 5th edge, product = 8'b0100_1110 (78).
- Carry-out path: a = 4'b1111, b = 4'b1111 → product = 8'b1110_0001 (225). Check that `cout` reaches `hi`.
- Zero/identity:
  - a = 4'b0000, b = 4'b1011 → product = 0.
  - Then a = 4'b1001, b = 4'b0001 → product = 8'h09.
  - Both results appear after exactly 5 edges each.
- Ignored start and back-to-back:
  - a = 4'b0111, b = 4'b1110; pulse `start` again mid-RUN with a = 4'b0001 → product = 98 (8'h62) and `done` occurs once.
  - Start in the DONE cycle with a = 4'b0010, b = 4'b1001 → product = 18 (8'h12) 5 edges later, with no IDLE gap.
- Reset mid-operation: start a = 4'b1110, b = 4'b1000, assert `rst` at the 2nd RUN edge → `busy` = 0, `product` = 0, no `done`. A following start with a = 4'b0011, b = 4'b0011 → product = 8'h09.
